// File: rtl/decim_avg.sv
// Block averager: sums DECIM signed samples, emits floor(sum/DECIM) into a 2-deep FIFO.
// Result visible one cycle after the last sample; full FIFO with no pop drops the result and sets overflow.
module fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic         vld_o,
  output logic         full_o
);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    do_push = push_i && ((cnt_q != CNT_FULL) || do_pop);
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_dat_i;
        wr_d        = wr_q + PTR_ONE;
      end
      if (do_pop) rd_d = rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_q];
  assign vld_o      = (cnt_q != '0);
  assign full_o     = (cnt_q == CNT_FULL);
endmodule

module decim_avg #(
  parameter int DECIM      = 8,
  parameter int LOG2_DECIM = 3
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic signed [15:0] data_i,
  input  logic               en_i,
  input  logic               clear_i,
  output logic signed [15:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               overflow_o
);
  localparam int                    ACC_W    = 16 + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CNT_LAST = LOG2_DECIM'(DECIM - 1);
  localparam logic [LOG2_DECIM-1:0] CNT_ONE  = LOG2_DECIM'(1);

  logic signed [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [LOG2_DECIM-1:0]    cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     last, push, pop, full, head_vld;
  logic [15:0]              head_dat, result;

  always_comb begin
    sum    = acc_q + {{LOG2_DECIM{data_i[15]}}, data_i};
    // Top 16 bits of the sum are the arithmetic shift by LOG2_DECIM (floor).
    result = sum[ACC_W-1 -: 16];
    last   = en_i && (cnt_q == CNT_LAST);
    push   = last && !clear_i;
    pop    = head_vld && ready_i && !clear_i;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
        if (full && !pop) ovf_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  fifo #(.W(16), .DEPTH(2), .AW(1)) u_out_fifo (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .flush_i    (clear_i),
    .push_i     (push),
    .push_dat_i (result),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .vld_o      (head_vld),
    .full_o     (full)
  );

  assign valid_o    = head_vld;
  assign data_o     = head_vld ? head_dat : '0;
  assign overflow_o = ovf_q;
endmodule

// File: tb/tb_decim_avg.sv
// Scoreboarded directed bench for decim_avg with DECIM=4.
module tb_decim_avg;
  logic               clk_i = 1'b0;
  logic               reset_ni = 1'b1;
  logic signed [15:0] data_i = '0;
  logic               en_i = 1'b0;
  logic               clear_i = 1'b0;
  logic               ready_i = 1'b1;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic               overflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk_i = ~clk_i;

  decim_avg #(.DECIM(4), .LOG2_DECIM(2)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .data_i     (data_i),
    .en_i       (en_i),
    .clear_i    (clear_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input int d);
    en_i   = e;
    data_i = d[15:0];
    @(posedge clk_i);
    #1;
  endtask

  task automatic block(input int d);
    repeat (4) step(1'b1, d);
  endtask

  // Each output accepted on the coming edge is compared against the oldest expected result.
  always @(negedge clk_i) begin
    if (reset_ni && valid_o && ready_i && !clear_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d expected none", data_o);
      end else begin
        chk("scoreboard_data", data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 reset_ni = 1'b0;
    #2;
    chk("reset_valid", valid_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_ovf", overflow_o, 0);
    @(posedge clk_i);
    #1 reset_ni = 1'b1;

    // Constant input: one-cycle pulse every 4 samples
    repeat (3) exp_q.push_back(100);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 100);
      chk("pulse_valid", valid_o, (k % 4 == 0) ? 1 : 0);
    end
    step(1'b0, 0);

    // Floor rounding of a negative sum
    exp_q.push_back(-2);
    step(1'b1, -1); step(1'b1, -1); step(1'b1, -1); step(1'b1, -2);
    chk("floor_data", data_o, -2);
    step(1'b0, 0);

    // Full-scale extremes do not wrap
    exp_q.push_back(32767);
    exp_q.push_back(-32768);
    block(32767);
    chk("max_data", data_o, 32767);
    block(-32768);
    chk("min_data", data_o, -32768);
    step(1'b0, 0);

    // Stall: third result dropped, overflow sticky until clear
    ready_i = 1'b0;
    exp_q.push_back(10);
    exp_q.push_back(20);
    block(10);
    chk("stall_valid", valid_o, 1);
    chk("stall_head", data_o, 10);
    block(20);
    chk("stall_ovf_clean", overflow_o, 0);
    block(30);
    chk("stall_ovf_set", overflow_o, 1);
    chk("stall_hold", data_o, 10);
    ready_i = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
    chk("drain_valid", valid_o, 0);
    chk("drain_ovf_sticky", overflow_o, 1);
    clear_i = 1'b1;
    step(1'b0, 0);
    clear_i = 1'b0;
    chk("clear_ovf", overflow_o, 0);
    chk("clear_valid", valid_o, 0);

    // Clear beats en_i/ready_i and discards partial block and that cycle's sample
    ready_i = 1'b0;
    block(40);
    chk("preclear_valid", valid_o, 1);
    step(1'b1, 99); step(1'b1, 99);
    clear_i = 1'b1;
    ready_i = 1'b1;
    step(1'b1, 99);
    clear_i = 1'b0;
    chk("clear_flush", valid_o, 0);
    exp_q.push_back(12);
    block(12);
    chk("postclear_data", data_o, 12);
    step(1'b0, 0);

    // Push and pop on the same edge with FIFO full
    ready_i = 1'b0;
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    block(1);
    block(2);
    step(1'b1, 3); step(1'b1, 3); step(1'b1, 3);
    ready_i = 1'b1;
    step(1'b1, 3);
    chk("full_pushpop_ovf", overflow_o, 0);
    chk("full_pushpop_head", data_o, 2);
    step(1'b0, 0);
    step(1'b0, 0);
    chk("full_pushpop_empty", valid_o, 0);

    // Asynchronous reset mid-block with FIFO full and overflow set
    ready_i = 1'b0;
    block(60); block(60); block(60);
    chk("prereset_ovf", overflow_o, 1);
    chk("prereset_data", data_o, 60);
    step(1'b1, 50); step(1'b1, 50);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_data", data_o, 0);
    chk("async_rst_ovf", overflow_o, 0);
    #1 reset_ni = 1'b1;
    ready_i = 1'b1;
    exp_q.push_back(8);
    block(8);
    chk("postreset_valid", valid_o, 1);
    chk("postreset_data", data_o, 8);
    repeat (3) step(1'b0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decim_avg.md
DECIM_AVG -- requirements
Module: decim_avg

Interface
REQ-001 SHALL have parameter DECIM, default 8, meaning samples per output; legal values are powers of two from 2 to 256.
REQ-002 SHALL have parameter LOG2_DECIM, default 3, meaning log2(DECIM); it SHALL equal log2(DECIM).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port data_i  input  16  signed filtered sample from the upstream low-pass filter output.
REQ-006 SHALL have port en_i  input  1  sample strobe; data_i is consumed on a cycle where en_i=1.
REQ-007 SHALL have port clear_i  input  1  synchronous flush of block state.
REQ-008 SHALL have port data_o  output  16  signed averaged sample at the output FIFO head.
REQ-009 SHALL have port valid_o  output  1  data_o holds a valid result.
REQ-010 SHALL have port ready_i  input  1  consumer accepts data_o.
REQ-011 SHALL have port overflow_o  output  1  sticky flag: a result was dropped.

Function
REQ-012 SHALL accumulate consumed samples in a signed accumulator of 16+LOG2_DECIM bits, sign-extending each sample, so that it never wraps.
REQ-013 SHALL count consumed samples in a counter running 0..DECIM-1.
REQ-014 On the DECIM-th consumed sample (en_i=1 with count=DECIM-1), SHALL form result = (acc + sign-extended data_i) arithmetically shifted right by LOG2_DECIM, i.e. floor rounding, truncated to 16 bits.
REQ-015 On that same edge, SHALL push the result into the output FIFO, reset acc to 0 and reset count to 0.
REQ-016 With en_i=0, acc and count SHALL hold.
REQ-017 Output FIFO SHALL be 2 entries deep, first in first out.
REQ-018 valid_o SHALL be 1 exactly when the FIFO is non-empty, and data_o SHALL equal the head entry.
REQ-019 data_o SHALL be 0 when the FIFO is empty.
REQ-020 A pop SHALL occur on an edge where valid_o=1 and ready_i=1.
REQ-021 data_o and valid_o SHALL NOT change while valid_o=1 and ready_i=0, except through clear_i or reset.
REQ-022 Latency: a result SHALL appear on data_o/valid_o in the cycle after the edge that consumed the DECIM-th sample, provided the FIFO was empty.
REQ-023 On a simultaneous push and pop with the FIFO full, both SHALL take effect, occupancy SHALL remain 2, and overflow_o SHALL NOT be set.
REQ-024 On a push with the FIFO full and no pop, the new result SHALL be discarded and overflow_o SHALL be set to 1.
REQ-025 Accumulation SHALL continue normally after a discarded result.
REQ-026 overflow_o SHALL stay at 1 until clear_i or reset.
REQ-027 clear_i=1 SHALL, on the next edge, zero acc, count and overflow_o and empty the FIFO.
REQ-028 clear_i SHALL take priority over en_i and ready_i in the same cycle; data_i in that cycle SHALL be discarded.
REQ-029 All outputs SHALL be registered or derived only from registered state, with no combinational path from data_i to data_o.

Reset
REQ-030 reset_ni=0 SHALL immediately, without waiting for a clock edge, set acc=0, count=0, FIFO empty, data_o=0, valid_o=0 and overflow_o=0.
REQ-031 Reset asserted mid-block SHALL discard the partial accumulation.
REQ-032 The first block after reset release SHALL start at count 0.

Verification (DECIM=4, LOG2_DECIM=2)
REQ-033 Stimulus: data_i=100, en_i=1 continuously, ready_i=1. Response: valid_o pulses for one cycle every 4 cycles with data_o=100; the first pulse is in the cycle after the 4th sample.
REQ-034 Stimulus: samples -1,-1,-1,-2. Response: data_o=-2 (sum -5, floor), not -1.
REQ-035 Stimulus: four samples of 32767, then four samples of -32768. Response: data_o=32767, then data_o=-32768, with no wrap.
REQ-036 Stimulus: ready_i=0 across three completed blocks of 10, 20 and 30. Response: 10 and 20 are held in that order, 30 is dropped, overflow_o=1. Then ready_i=1 yields 10 then 20, and overflow_o stays at 1 until clear_i, after which valid_o=0 and overflow_o=0.
REQ-037 Stimulus: FIFO full, ready_i=1 on the same edge a 3rd result is pushed. Response: no overflow, and outputs follow in push order.
REQ-038 Stimulus: reset_ni pulsed low between clock edges after 2 samples of 50, then four samples of 8. Response: outputs are 0 immediately on reset, and the next result is 8.
